// File: rtl/m2p_pkg.sv
// Shared types and constants for the method-to-pipe beat marshaller.
// Header beat layout, message queue entry and serialiser states.
package m2p_pkg;

    localparam int IDX_W          = 16;
    localparam int PORTAL_W       = 16;
    localparam int HDR_PORTAL_LSB = 0;
    localparam int HDR_IDX_LSB    = HDR_PORTAL_LSB + PORTAL_W;
    localparam int LENGTH_W       = 16;
    localparam int WORDS_W        = 8;
    localparam int MSG_PAYLOAD_W  = 128;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } ser_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [WORDS_W-1:0] words;
    } msg_hdr_t;

    typedef struct packed {
        logic [IDX_W-1:0]         idx;
        logic [WORDS_W-1:0]       words;
        logic [MSG_PAYLOAD_W-1:0] payload;
    } msg_entry_t;

endpackage

// File: rtl/m2p_msg_fifo.sv
// Whole-message queue between the method arbiter and the serialiser.
// Exposes the head entry plus a peek at the header of the entry behind it.
module m2p_msg_fifo
    import m2p_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       push_i,
    input  msg_entry_t wdata_i,
    input  logic       pop_i,
    output msg_entry_t head_o,
    output msg_hdr_t   head_nxt_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       multi_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    msg_entry_t    mem_q [DEPTH];
    logic [AW:0]   wp_q;
    logic [AW:0]   wp_d;
    logic [AW:0]   rp_q;
    logic [AW:0]   rp_d;
    logic [AW:0]   cnt;
    logic [AW-1:0] rp_nxt;

    // Occupancy never exceeds DEPTH, so the top bit alone means full.
    assign cnt     = wp_q - rp_q;
    assign full_o  = cnt[AW];
    assign empty_o = (cnt == '0);
    assign multi_o = (cnt > PW'(1));
    assign rp_nxt  = rp_q[AW-1:0] + AW'(1);

    assign head_o           = mem_q[rp_q[AW-1:0]];
    assign head_nxt_o.idx   = mem_q[rp_nxt].idx;
    assign head_nxt_o.words = mem_q[rp_nxt].words;

    // Pointer advance; overflow and underflow requests are ignored.
    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (push_i && !full_o) begin
            wp_d = wp_q + PW'(1);
        end
        if (pop_i && !empty_o) begin
            rp_d = rp_q + PW'(1);
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (push_i && !full_o) begin
            mem_q[wp_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/m2p_beat_marshaller.sv
// Round-robin method-call arbiter feeding a message FIFO, and a
// serialiser that emits one header beat plus payload beats per message.
module m2p_beat_marshaller
    import m2p_pkg::*;
#(
    parameter int NUM_METHODS = 4,
    parameter int PAYLOAD_W   = 128,
    parameter int BEAT_W      = 32,
    parameter int PORTAL_ID   = 5,
    parameter int DEPTH       = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_METHODS-1:0]         meth_ena,
    input  logic [NUM_METHODS*PAYLOAD_W-1:0] meth_payload,
    input  logic [NUM_METHODS*WORDS_W-1:0] meth_words,
    output logic [NUM_METHODS-1:0]         meth_rdy,
    output logic                           pipe_enq_ena,
    output logic [BEAT_W-1:0]              pipe_enq_data,
    output logic [LENGTH_W-1:0]            pipe_enq_length,
    output logic                           pipe_enq_last,
    input  logic                           pipe_enq_rdy,
    output logic                           err_len
);

    localparam int MAX_WORDS = PAYLOAD_W / BEAT_W;
    localparam int RR_W = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;

    logic [RR_W-1:0]        rr_q;
    logic [RR_W-1:0]        rr_d;
    logic [NUM_METHODS-1:0] grant;
    logic [RR_W-1:0]        gidx;
    logic                   found;
    logic                   push;
    logic                   pop;
    logic [WORDS_W-1:0]     raw_words;
    logic                   over;
    msg_entry_t             wr_ent;
    msg_entry_t             head;
    msg_hdr_t               head_nxt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_multi;
    logic                   err_q;
    logic                   err_d;

    ser_state_e             state_q;
    ser_state_e             state_d;
    logic [WORDS_W-1:0]     beat_q;
    logic [WORDS_W-1:0]     beat_d;
    logic                   ena_q;
    logic                   ena_d;
    logic [BEAT_W-1:0]      data_q;
    logic [BEAT_W-1:0]      data_d;
    logic [LENGTH_W-1:0]    len_q;
    logic [LENGTH_W-1:0]    len_d;
    logic                   last_q;
    logic                   last_d;
    logic                   load;
    logic                   done;
    logic [IDX_W-1:0]       nxt_idx;
    logic [WORDS_W-1:0]     nxt_words;

    // Pick the first requesting channel at or after the rr pointer.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_METHODS; k++) begin
            c = (int'(rr_q) + k) % NUM_METHODS;
            if (!found && meth_ena[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                gidx     = RR_W'(c);
            end
        end
    end

    // Full is the registered queue state, so a same-cycle pop never helps.
    assign meth_rdy = grant & {NUM_METHODS{!fifo_full && !RST}};
    assign push     = |meth_rdy;

    // Build the queue entry for the granted caller, clamping its length.
    always_comb begin
        raw_words      = meth_words[gidx*WORDS_W +: WORDS_W];
        over           = (raw_words > WORDS_W'(MAX_WORDS));
        wr_ent.idx     = IDX_W'(gidx);
        wr_ent.words   = over ? WORDS_W'(MAX_WORDS) : raw_words;
        wr_ent.payload = MSG_PAYLOAD_W'(meth_payload[gidx*PAYLOAD_W +: PAYLOAD_W]);
        rr_d           = push ? RR_W'((int'(gidx) + 1) % NUM_METHODS) : rr_q;
        err_d          = err_q | (push & over);
    end

    m2p_msg_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push_i    (push),
        .wdata_i   (wr_ent),
        .pop_i     (pop),
        .head_o    (head),
        .head_nxt_o(head_nxt),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .multi_o   (fifo_multi)
    );

    // Serialiser next state and next registered beat.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        ena_d     = ena_q;
        data_d    = data_q;
        len_d     = len_q;
        last_d    = last_q;
        pop       = 1'b0;
        load      = 1'b0;
        done      = 1'b0;
        nxt_idx   = wr_ent.idx;
        nxt_words = wr_ent.words;

        // Source of the next header: queue head when idle, the entry
        // behind the head after a pop, else the call accepted right now.
        if (state_q == IDLE && !fifo_empty) begin
            nxt_idx   = head.idx;
            nxt_words = head.words;
        end else if (state_q != IDLE && fifo_multi) begin
            nxt_idx   = head_nxt.idx;
            nxt_words = head_nxt.words;
        end

        unique case (state_q)
            IDLE: begin
                load = !fifo_empty || push;
            end
            HDR: begin
                if (pipe_enq_rdy) begin
                    if (head.words == '0) begin
                        done = 1'b1;
                    end else begin
                        state_d = BODY;
                        beat_d  = '0;
                        data_d  = BEAT_W'(head.payload);
                        last_d  = (head.words == WORDS_W'(1));
                    end
                end
            end
            BODY: begin
                if (pipe_enq_rdy) begin
                    if (last_q) begin
                        done = 1'b1;
                    end else begin
                        beat_d = beat_q + WORDS_W'(1);
                        data_d = BEAT_W'(head.payload >> (int'(beat_d) * BEAT_W));
                        last_d = (beat_d == head.words - WORDS_W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            pop  = 1'b1;
            load = fifo_multi || push;
        end

        if (load) begin
            state_d = HDR;
            beat_d  = '0;
            ena_d   = 1'b1;
            data_d  = BEAT_W'({nxt_idx, PORTAL_W'(PORTAL_ID)});
            len_d   = LENGTH_W'(nxt_words) + LENGTH_W'(1);
            last_d  = (nxt_words == '0);
        end else if (done) begin
            state_d = IDLE;
            ena_d   = 1'b0;
            data_d  = '0;
            len_d   = '0;
            last_d  = 1'b0;
        end
    end

    // State, rr pointer, error flag and beat output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            ena_q   <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ena_q   <= ena_d;
            data_q  <= data_d;
            len_q   <= len_d;
            last_q  <= last_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    assign pipe_enq_ena    = ena_q;
    assign pipe_enq_data   = data_q;
    assign pipe_enq_length = len_q;
    assign pipe_enq_last   = last_q;
    assign err_len         = err_q;

endmodule

// File: doc/m2p_beat_marshaller.md
Name: m2p_beat_marshaller

Overview:
Parametrised successor to the fixed single-word indication marshaller. Accepts up to NUM_METHODS indication method calls, each with a variable-length payload. Queues whole messages in a small FIFO. Serialises each message onto a BEAT_W-wide outbound pipe as one header beat followed by payload beats, with a last-beat flag. Sits between the generated indication method ports and the portal transport pipe.

Parameters:
NUM_METHODS, 4, number of method channels; method index = channel number
PAYLOAD_W, 128, max payload bits per method; multiple of BEAT_W
BEAT_W, 32, outbound beat width; fixed at 32 in this generation
PORTAL_ID, 5, 16-bit portal number placed in every header
DEPTH, 4, message FIFO depth; power of 2, ≥2

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
meth_ena  in  NUM_METHODS  per-channel call request; sticky, held until accepted
meth_payload  in  NUM_METHODS*PAYLOAD_W  channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]; word 0 is the LSBs
meth_words  in  NUM_METHODS*8  payload word count for channel i (0..PAYLOAD_W/32)
meth_rdy  out  NUM_METHODS  channel i call accepted this cycle when ena[i]&rdy[i]
pipe_enq_ena  out  1  beat valid
pipe_enq_data  out  BEAT_W  beat data
pipe_enq_length  out  16  total words in message, including header; stable for all beats of the message
pipe_enq_last  out  1  final beat of the message
pipe_enq_rdy  in  1  sink accepts beat when ena&rdy
err_len  out  1  sticky: a meth_words value above MAX_WORDS was seen

Behaviour:
- MAX_WORDS = PAYLOAD_W/32.
- Reset (async assert, sync release): FIFO empty; rr pointer = 0; serialiser in IDLE; pipe_enq_ena=0; data/length/last=0; err_len=0; meth_rdy=0.
- Arbitration:
  - Round-robin grant among asserted meth_ena, starting at rr_ptr.
  - meth_rdy[i] = !fifo_full & grant[i]; at most one bit is set.
  - On acceptance, rr_ptr advances to (granted+1) mod NUM_METHODS.
  - A non-granted caller holds ena and is served within NUM_METHODS accepts.
- Enqueue stores {idx, words_clamped, payload}. words > MAX_WORDS is clamped to MAX_WORDS and sets err_len.
- Serialiser FSM:
  - IDLE: if FIFO non-empty, load head and go to HDR.
  - HDR: ena=1; data = {idx[15:0], PORTAL_ID[15:0]}; length = words+1; last = (words==0). On ena&rdy: if words==0, pop and go to IDLE (or reload HDR if FIFO still non-empty); else go to BODY with beat_cnt=0.
  - BODY: data = payload word beat_cnt; last = (beat_cnt==words-1). On ena&rdy: beat_cnt++; on the last beat, pop and go to HDR if FIFO still non-empty, else IDLE.
- All pipe_enq_* outputs are registered. data, length and last stay stable while ena=1 and rdy=0.
- Latency: call accepted in cycle t gives its header beat in cycle t+1 if the FIFO was empty and the serialiser idle. Back-to-back messages have no bubble between the last beat and the next header.
- Simultaneous enqueue and pop when full: the pop frees a slot only next cycle. meth_rdy uses the registered full flag only.
- RST mid-message: the partial message is discarded; the pipe sees ena drop asynchronously.

Decomposition:
- Shared package m2p_pkg holds:
  - header field widths and offsets (idx 16, portal 16);
  - the LENGTH_W=16 constant;
  - the FSM state enum {IDLE, HDR, BODY};
  - the msg_entry_t struct {idx, words, payload}.
- Sub-module m2p_msg_fifo: DEPTH×entry synchronous FIFO with full/empty, on the same CLK/RST.

Test Plan:
1. Single call: ch2 ena, words=1, payload word0=0xDEADBEEF, rdy=1 → beats {0x00020005 len=2 last=0}, {0xDEADBEEF len=2 last=1}; meth_rdy[2] high for 1 cycle.
2. Header-only: ch0 words=0 → one beat 0x00000005, len=1, last=1.
3. Contention: ch1 and ch3 ena together, rr_ptr=0 → ch1 accepted first, ch3 next cycle. Header order 0x00010005 then 0x00030005; rr_ptr ends at 0.
4. Backpressure: ch0 words=3, rdy toggles 1,0,0,1,1,1 → 4 beats with data stable during stalls; last only on word2. Fill FIFO with 4 messages under rdy=0 → meth_rdy=0 while full; frees after one pop.
5. Clamp: words=9 with PAYLOAD_W=128 → len=5, 4 payload beats, err_len=1 until reset.
6. Reset mid-BODY → pipe_enq_ena=0 immediately; after release the FIFO is empty and the next call starts at HDR.
